// File: rtl/inst_fetch_unit.sv
//==============================================================================
// Module      : inst_fetch_unit
// Description : Instruction fetch stage. Owns the PC, addresses the ROM, and
//               queues {pc, instr} pairs in a 2-entry buffer for decode.
//               Optional misaligned-redirect trap: IFU_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err
);

    localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;
    localparam logic [1:0]  c_depth      = 2'd2;

    logic [31:0] r_pc;
    logic [31:0] r_ent_pc    [0:1];
    logic [31:0] r_ent_instr [0:1];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_valid;
    logic        w_pop;
    logic        w_space;
    logic        w_push;
    logic        w_halted;
    logic [31:0] w_redirect_aligned;

    assign w_redirect_aligned = redirect_pc & c_align_mask;
    assign instr_addr         = r_pc;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & if_ready;
    // A full buffer can still accept a new entry when the head leaves this cycle.
    assign w_space = (r_count < c_depth) | w_pop;
    assign w_push  = fetch_en & w_space & ~redirect_valid & ~w_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= w_redirect_aligned;
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Entry storage needs no reset: r_count masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ent_pc[r_wr_ptr]    <= r_pc;
            r_ent_instr[r_wr_ptr] <= instr_data;
        end
    end

    assign if_valid = w_valid;
    assign if_pc    = w_valid ? r_ent_pc[r_rd_ptr]    : 32'h0000_0000;
    assign if_instr = w_valid ? r_ent_instr[r_rd_ptr] : NOP_INSTR;

`ifdef IFU_MISALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign w_halted     = r_misalign;
    assign misalign_err = r_misalign;
`else
    assign w_halted     = 1'b0;
    assign misalign_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
`default_nettype none

module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign instr_data = rom(instr_addr);

    inst_fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_addr    (instr_addr),
        .instr_data    (instr_data),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .misalign_err  (misalign_err)
    );

    // Reference model: an ordered queue of {pc, instr}, a pc and a halt flag.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        e_pc    = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
        e_instr = (mq.size() != 0) ? mq[0][31:0]  : NOP_INSTR;
        chk({tag, ".addr"},  instr_addr, m_pc);
        chk({tag, ".valid"}, {31'b0, if_valid}, {31'b0, mq.size() != 0});
        chk({tag, ".pc"},    if_pc, e_pc);
        chk({tag, ".instr"}, if_instr, e_instr);
        chk({tag, ".err"},   {31'b0, misalign_err}, {31'b0, m_err});
    endtask

    task automatic model_tick();
        bit pop;
        bit push;
        if (reset) begin
            mq.delete();
            m_pc  = RESET_PC;
            m_err = 1'b0;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
`ifdef IFU_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
`endif
        end else begin
            pop  = (mq.size() != 0) && if_ready;
            push = fetch_en && !m_err && ((mq.size() < 2) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_pc, rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic fe,
                        input logic rv, input logic [31:0] rpc, input logic rdy);
        reset          = rst;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        model_tick();
        #1;
    endtask

    initial begin
        logic [31:0] rpc;
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; if_ready = 1'b0;
        mq.delete(); m_pc = RESET_PC; m_err = 1'b0;
        @(posedge clk);
        model_tick();
        #1;

        // Reset release and streaming
        step("p1_rst", 1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("p1_run", 0, 1, 0, 0, 1);
        chk("p1_head12", if_pc, 32'h0000_000C);

        // Backpressure
        step("p2_rst", 1, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) step("p2_hold", 0, 1, 0, 0, 0);
        chk("p2_addr_frozen", instr_addr, 32'h0000_0008);
        for (int i = 0; i < 5; i++) step("p2_drain", 0, 1, 0, 0, 1);

        // Redirect while full
        step("p3_rst", 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("p3_fill", 0, 1, 0, 0, 0);
        step("p3_redir", 0, 1, 1, 32'h0000_0100, 0);
        step("p3_bubble", 0, 1, 0, 0, 0);
        chk("p3_tgt_pc", if_pc, 32'h0000_0100);
        chk("p3_tgt_instr", if_instr, 32'h1000_0040);

        // Redirect coinciding with a ready head, then back-to-back redirects
        step("p4_fill", 0, 1, 0, 0, 0);
        step("p4_redir_rdy", 0, 1, 1, 32'h0000_0200, 1);
        step("p4_r40", 0, 1, 1, 32'h0000_0040, 1);
        step("p4_r80", 0, 1, 1, 32'h0000_0080, 1);
        step("p4_bubble", 0, 1, 0, 0, 0);
        chk("p4_head80", if_pc, 32'h0000_0080);

        // Address wrap, then reset while full
        step("p5_redir", 0, 1, 1, 32'hFFFF_FFFC, 1);
        for (int i = 0; i < 3; i++) step("p5_wrap", 0, 1, 0, 0, 1);
        chk("p5_head4", if_pc, 32'h0000_0004);
        for (int i = 0; i < 3; i++) step("p5_fill", 0, 1, 0, 0, 0);
        step("p5_rst", 1, 1, 0, 0, 0);
        chk("p5_rst_valid", {31'b0, if_valid}, 32'h0);
        chk("p5_rst_instr", if_instr, NOP_INSTR);

        // Misaligned redirect
        step("p6_run", 0, 1, 0, 0, 1);
        step("p6_redir", 0, 1, 1, 32'h0000_0102, 1);
        for (int i = 0; i < 4; i++) step("p6_after", 0, 1, 0, 0, 1);
        step("p6_rst", 1, 1, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                1:       rpc = $urandom & 32'h0000_03FC;
                2:       rpc = $urandom & 32'h0000_03FF;
                default: rpc = $urandom;
            endcase
            step("rnd", ($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 11) == 0), rpc, ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM byte address. The ROM returns a word combinationally from addr[31:2].
- Captures {pc, instruction} pairs into a 2-entry fetch buffer and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the buffer.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr while if_valid=0 (ADDI x0,x0,0).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- instr_addr  output  32  byte address to ROM; equals current pc.
- instr_data  input  32  ROM read data for instr_addr; combinational, same cycle.
- fetch_en  input  1  1 = fetching allowed; 0 = pc holds and no push.
- redirect_valid  input  1  pulse; load pc from redirect_pc and flush the buffer.
- redirect_pc  input  32  redirect target byte address.
- if_valid  output  1  buffer head holds a valid instruction.
- if_ready  input  1  decode accepts the head this cycle.
- if_instr  output  32  head instruction; NOP_INSTR when if_valid=0.
- if_pc  output  32  head pc; 0 when if_valid=0.
- misalign_err  output  1  sticky misaligned-redirect flag; see Optional Feature.

Behaviour:
- Clock and reset: single clock domain, clk; all state updates on the rising edge.
- Reset values: reset=1 gives pc=RESET_PC, count=0, if_valid=0, if_instr=NOP_INSTR, if_pc=0, misalign_err=0.
  - Reset overrides everything, including redirect_valid in the same cycle.
  - Reset mid-stream discards all buffered entries.
- instr_addr = pc, combinational.
- Buffer: 2-entry FIFO of {pc[31:0], instr[31:0]}; count 0..2; head drives if_pc/if_instr.
  - if_valid = (count != 0).
- pop = if_valid & if_ready.
- space = (count < 2) | pop.
- push = fetch_en & space & ~redirect_valid & ~halted.
  - halted is 0 unless the optional feature is enabled.
  - On push: the entry {pc, instr_data} is written, and pc <= pc + 4.
  - pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Latency: an instruction fetched in cycle N is visible on if_valid/if_instr in cycle N+1.
  - Sustained throughput is 1 instruction/cycle while if_ready=1.
- Full (count=2):
  - Without a pop: no push, pc holds, instr_addr stable, entries unchanged.
  - With a pop: push and pop occur together and count stays 2.
- Empty (count=0): pop is impossible, and if_ready is ignored.
- Redirect has the highest priority after reset.
  - In the redirect cycle: count <= 0 and pc <= {redirect_pc[31:2], 2'b00}.
  - There is no push and no pop that cycle, regardless of if_ready.
  - if_valid=0 in cycle N+1; the target instruction is valid in cycle N+2, provided fetch_en=1.
- Back-to-back redirects: the last one wins, and each one flushes the buffer.
- fetch_en=0: the buffer still drains through pops, and pc freezes.
- Ordering: buffer entries are strictly in fetch order; no entry is duplicated or skipped.
- No state machine beyond the FIFO pointers, count, pc, and the halt flag.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 still flushes the buffer and loads the aligned pc.
  - It also sets misalign_err=1 and halted=1; both are sticky until reset.
  - While halted there are no pushes; the buffer stays empty, so if_valid=0.
- Undefined: the low two bits are silently cleared, misalign_err is tied to 0, and halted is constant 0.

Test Plan:
1. Reset release, ROM word[i] = 32'h1000_0000 + i, if_ready=1, fetch_en=1:
   - First cycle after reset: instr_addr=0.
   - Next cycle: if_valid=1, if_pc=0, if_instr=32'h1000_0000.
   - Then if_pc 4, 8, 12 on consecutive cycles.
2. Backpressure: hold if_ready=0 for 5 cycles after the first fetch.
   - count reaches 2 and instr_addr freezes at 8.
   - Release if_ready: the entries at pc 0, 4, 8, 12 emerge in order with no gap.
3. Redirect while full, redirect_pc=32'h0000_0100:
   - if_valid=0 in the next cycle.
   - The cycle after: if_pc=32'h100, if_instr=word[64].
   - The old entries at 4 and 8 are never accepted.
4. Simultaneous redirect and if_ready=1 while valid:
   - No pop is counted and the buffer is flushed.
   - Back-to-back redirects to 0x40 then 0x80: only 0x80 appears.
5. Wrap: redirect to 32'hFFFF_FFFC with ROM data stubbed:
   - if_pc sequence is FFFF_FFFC, 0000_0000, 0000_0004.
   - Assert reset while count=2: all outputs return to reset values next cycle.
6. Misaligned redirect to 32'h0000_0102:
   - Macro defined: if_pc never shows 0x100, misalign_err=1, and if_valid stays 0 until reset.
   - Macro undefined: the target executes from 0x100 and misalign_err=0.
